// File: rtl/regfile_pkg.sv
// Shared sizing and types for the register file, its interface bundle and its users.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  // DEPTH follows the address width so every address is a real register.
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/regfile_if.sv
// Signal bundle for one write port and one asynchronous read port of the register file.
interface regfile_if;
  import regfile_pkg::*;

  // Write: write_en qualifies write_addr/write_data on the rising clock edge; there is
  // no ready/backpressure, so a strobed write always lands one edge later.
  logic  write_en;
  addr_t write_addr;
  word_t write_data;
  addr_t read_addr;
  word_t read_data;

  modport dut (
    input  write_en,
    input  write_addr,
    input  write_data,
    input  read_addr,
    output read_data
  );

  modport tb (
    output write_en,
    output write_addr,
    output write_data,
    output read_addr,
    input  read_data
  );

endinterface

// File: rtl/regfile_sync_rst.sv
// Register file with synchronous active-low clear, one write port and a combinational read.
module regfile_sync_rst
  import regfile_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  regfile_if.dut intf
);

  word_t mem [DEPTH];

  // Reset wins over a same-edge write; address 0 is an ordinary register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (intf.write_en) begin
      mem[intf.write_addr] <= intf.write_data;
    end
  end

  // No write bypass: a same-address read shows the old word until the write edge.
  assign intf.read_data = mem[intf.read_addr];

  a_write_en_known : assert property (@(posedge clk) rst_n |-> !$isunknown(intf.write_en));

endmodule

// File: tb/tb_regfile_sync_rst.sv
// Self-checking bench for regfile_sync_rst: reference array plus expected-value queue.
module tb_regfile_sync_rst;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;

  regfile_if intf ();

  regfile_sync_rst dut (
    .clk   (clk),
    .rst_n (rst_n),
    .intf  (intf)
  );

  word_t model [DEPTH];
  word_t exp_q [$];
  int    checks   = 0;
  int    failures = 0;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n           = 1'b0;
    intf.write_en   = 1'b0;
    intf.write_addr = '0;
    intf.write_data = '0;
    intf.read_addr  = '0;
  end

  task automatic check_eq(input string tag, input word_t obs, input word_t exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: read_data=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle of reset/write stimulus, reference model updated on the edge
  task automatic drive_cycle(input logic r, input logic en, input addr_t a, input word_t d);
    @(negedge clk);
    rst_n           = r;
    intf.write_en   = en;
    intf.write_addr = a;
    intf.write_data = d;
    @(posedge clk);
    if (!r) begin
      foreach (model[i]) model[i] = '0;
    end else if (en) begin
      model[a] = d;
    end
    #1;
    rst_n         = 1'b1;
    intf.write_en = 1'b0;
  endtask

  // scoreboard: expectation pushed as the address is driven, popped once read_data settles
  task automatic expect_now(input addr_t a, input string tag);
    intf.read_addr = a;
    exp_q.push_back(model[a]);
    #1;
    check_eq(tag, intf.read_data, exp_q.pop_front());
  endtask

  task automatic expect_read(input addr_t a, input string tag);
    @(negedge clk);
    expect_now(a, tag);
  endtask

  initial begin
    word_t val_a;
    word_t val_b;
    addr_t ra;

    // 1: reset with a concurrent write; everything reads zero, write dropped
    drive_cycle(1'b0, 1'b1, addr_t'(3), 32'h1234_5678);
    for (int i = 0; i < DEPTH; i++) begin
      expect_read(addr_t'(i), $sformatf("reset_clear[%0d]", i));
    end

    // 2: address 0 is writable
    drive_cycle(1'b1, 1'b1, addr_t'(0), 32'h0000_ffff);
    expect_read(addr_t'(0), "addr0_write");

    // 3: back-to-back writes
    drive_cycle(1'b1, 1'b1, addr_t'(2), 32'h0000_fffc);
    drive_cycle(1'b1, 1'b1, addr_t'(31), 32'h0000_fff0);
    expect_read(addr_t'(2), "b2b_addr2");
    expect_read(addr_t'(31), "b2b_addr31");
    expect_read(addr_t'(0), "b2b_addr0_kept");

    // read follows read_addr within one cycle
    @(negedge clk);
    expect_now(addr_t'(2), "same_cycle_addr2");
    expect_now(addr_t'(31), "same_cycle_addr31");
    expect_now(addr_t'(0), "same_cycle_addr0");

    // 4: read-during-write to the same address, old value until the edge
    val_a = 32'haaaa_5555;
    val_b = 32'h1357_9bdf;
    drive_cycle(1'b1, 1'b1, addr_t'(5), val_a);
    @(negedge clk);
    intf.read_addr  = addr_t'(5);
    intf.write_en   = 1'b1;
    intf.write_addr = addr_t'(5);
    intf.write_data = val_b;
    expect_now(addr_t'(5), "rdw_before_edge");
    @(posedge clk);
    model[5] = val_b;
    #1;
    intf.write_en = 1'b0;
    expect_now(addr_t'(5), "rdw_after_edge");

    // 5: write_en low leaves contents alone
    drive_cycle(1'b1, 1'b0, addr_t'(31), 32'hdead_beef);
    expect_read(addr_t'(31), "no_write_addr31");

    // 6: mid-operation reset wipes contents, then writes resume
    drive_cycle(1'b0, 1'b1, addr_t'(2), 32'hcafe_f00d);
    expect_read(addr_t'(0), "midrst_addr0");
    expect_read(addr_t'(2), "midrst_addr2");
    expect_read(addr_t'(31), "midrst_addr31");
    expect_read(addr_t'(5), "midrst_addr5");
    drive_cycle(1'b1, 1'b1, addr_t'(2), 32'h8000_0001);
    expect_read(addr_t'(2), "post_rst_write");

    // random mixed traffic
    for (int n = 0; n < 60; n++) begin
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), addr_t'($urandom_range(0, DEPTH - 1)),
                  word_t'($urandom));
      ra = addr_t'($urandom_range(0, DEPTH - 1));
      expect_read(ra, $sformatf("rand[%0d]_addr%0d", n, ra));
    end

    for (int i = 0; i < DEPTH; i++) begin
      expect_read(addr_t'(i), $sformatf("final_sweep[%0d]", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
